// File: rtl/reg_dump_pkg.sv
// Shared types for the register dump reader: FSM state encoding and index-width helper.
package reg_dump_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_FETCH = 2'd1;
  localparam logic [1:0] ENC_SEND  = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_FETCH = ENC_FETCH,
    ST_SEND  = ENC_SEND,
    ST_DONE  = ENC_DONE
  } state_t;

  // Width of a register index; never below 1 so ports stay legal.
  function automatic int idx_width(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/reg_dump_reader_register.sv
// Generic enabled holding register with asynchronous active-low clear.
module register #(
  parameter int P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic               I_ENABLE,
  input  logic [P_WIDTH-1:0] I_D,
  output logic [P_WIDTH-1:0] O_Q
);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      O_Q <= '0;
    end else if (I_ENABLE) begin
      O_Q <= I_D;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file from index 0 upward and streams each word on a
// valid/ready port, one FETCH cycle plus at least one SEND cycle per word.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int P_WIDTH    = 16,
  parameter int P_NUM_REGS = 16,
  localparam int IW        = idx_width(P_NUM_REGS)
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic               I_START,
  input  logic               I_ABORT,
  input  logic [P_WIDTH-1:0] I_REG_DATA,
  output logic [IW-1:0]      O_REG_ADDR,
  output logic               O_VALID,
  input  logic               I_READY,
  output logic [P_WIDTH-1:0] O_DATA,
  output logic [IW-1:0]      O_INDEX,
  output logic               O_LAST,
  output logic               O_BUSY,
  output logic               O_DONE,
  output logic [1:0]         O_STATE
);

  // Handshake: a word transfers on a rising edge where O_VALID && I_READY;
  // while O_VALID is high, O_DATA/O_INDEX/O_LAST hold and O_VALID never drops
  // without an accept except on I_ABORT or reset.

  localparam logic [IW-1:0] LAST_IDX = IW'(P_NUM_REGS - 1);

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;
  logic [IW-1:0]   index_q;
  logic            last_q;
  logic            fetch_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (I_START) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (I_READY) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    // Abort wins over a same-cycle accept: that word is treated as undelivered.
    if (I_ABORT && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign fetch_en = (state_q == ST_FETCH);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      index_q <= '0;
      last_q  <= 1'b0;
    end else if (fetch_en) begin
      index_q <= idx_q;
      last_q  <= (idx_q == LAST_IDX);
    end
  end

  register #(
    .P_WIDTH (P_WIDTH)
  ) u_data_reg (
    .I_CLK    (I_CLK),
    .I_NRESET (I_NRESET),
    .I_ENABLE (fetch_en),
    .I_D      (I_REG_DATA),
    .O_Q      (O_DATA)
  );

  // idx_q is forced to 0 whenever IDLE, so the address is 0 there too.
  assign O_REG_ADDR = idx_q;
  assign O_VALID    = (state_q == ST_SEND);
  assign O_INDEX    = index_q;
  assign O_LAST     = last_q && (state_q == ST_SEND);
  assign O_BUSY     = (state_q != ST_IDLE);
  assign O_DONE     = (state_q == ST_DONE);
  assign O_STATE    = state_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a 16-entry register file model.
module tb_reg_dump_reader;

  logic        I_CLK;
  logic        I_NRESET;
  logic        I_START;
  logic        I_ABORT;
  logic [15:0] I_REG_DATA;
  logic [3:0]  O_REG_ADDR;
  logic        O_VALID;
  logic        I_READY;
  logic [15:0] O_DATA;
  logic [3:0]  O_INDEX;
  logic        O_LAST;
  logic        O_BUSY;
  logic        O_DONE;
  logic [1:0]  O_STATE;

  logic [15:0] rf [16];
  int checks;
  int errors;

  assign I_REG_DATA = rf[O_REG_ADDR];

  reg_dump_reader #(
    .P_WIDTH    (16),
    .P_NUM_REGS (16)
  ) dut (
    .I_CLK      (I_CLK),
    .I_NRESET   (I_NRESET),
    .I_START    (I_START),
    .I_ABORT    (I_ABORT),
    .I_REG_DATA (I_REG_DATA),
    .O_REG_ADDR (O_REG_ADDR),
    .O_VALID    (O_VALID),
    .I_READY    (I_READY),
    .O_DATA     (O_DATA),
    .O_INDEX    (O_INDEX),
    .O_LAST     (O_LAST),
    .O_BUSY     (O_BUSY),
    .O_DONE     (O_DONE),
    .O_STATE    (O_STATE)
  );

  // clock / reset
  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  task automatic preset_rf();
    for (int i = 0; i < 16; i++) rf[i] = 16'(16'hA000 + i);
  endtask

  // Leaves the bench at the falling edge of cycle 1 (FETCH of index 0).
  task automatic start_dump();
    @(negedge I_CLK);
    I_START = 1'b1;
    @(negedge I_CLK);
    I_START = 1'b0;
  endtask

  task automatic test_reset();
    I_NRESET = 1'b0;
    I_START  = 1'b0;
    I_ABORT  = 1'b0;
    I_READY  = 1'b0;
    preset_rf();
    repeat (2) @(negedge I_CLK);
    checks++;
    if ({O_REG_ADDR, O_VALID, O_DATA, O_INDEX, O_LAST, O_BUSY, O_DONE, O_STATE} !== '0)
      $display("FAIL reset_outputs: got addr=%0h v=%0b d=%0h idx=%0h l=%0b b=%0b dn=%0b st=%0d, expected all 0",
               O_REG_ADDR, O_VALID, O_DATA, O_INDEX, O_LAST, O_BUSY, O_DONE, O_STATE);
    if ({O_REG_ADDR, O_VALID, O_DATA, O_INDEX, O_LAST, O_BUSY, O_DONE, O_STATE} !== '0) errors++;
    I_NRESET = 1'b1;
    @(negedge I_CLK);
    checks++;
    if (O_BUSY !== 1'b0 || O_STATE !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%0b state=%0d expected 0 0", O_BUSY, O_STATE);
    end
  endtask

  task automatic test_full_dump();
    int exp_idx;
    int cyc;
    bit done_seen;
    preset_rf();
    I_READY = 1'b1;
    start_dump();
    cyc = 1;
    exp_idx = 0;
    done_seen = 0;
    checks++;
    if (O_REG_ADDR !== 4'd0 || O_BUSY !== 1'b1 || O_VALID !== 1'b0 || O_STATE !== 2'd1) begin
      errors++;
      $display("FAIL full_fetch0: got addr=%0h busy=%0b valid=%0b st=%0d expected 0 1 0 1",
               O_REG_ADDR, O_BUSY, O_VALID, O_STATE);
    end
    while (!done_seen && cyc < 80) begin
      if (O_VALID) begin
        if (exp_idx == 0) begin
          checks++;
          if (cyc != 2) begin
            errors++;
            $display("FAIL full_first_valid_cycle: got %0d expected 2", cyc);
          end
        end
        checks++;
        if (O_DATA !== 16'(16'hA000 + exp_idx) || O_INDEX !== 4'(exp_idx) ||
            O_LAST !== (exp_idx == 15)) begin
          errors++;
          $display("FAIL full_word: got data=%0h idx=%0d last=%0b expected data=%0h idx=%0d last=%0b",
                   O_DATA, O_INDEX, O_LAST, 16'(16'hA000 + exp_idx), exp_idx, exp_idx == 15);
        end
        exp_idx++;
      end
      if (O_DONE) begin
        done_seen = 1;
        checks++;
        if (cyc != 33) begin
          errors++;
          $display("FAIL full_done_cycle: got %0d expected 33", cyc);
        end
      end
      @(negedge I_CLK);
      cyc++;
    end
    checks++;
    if (!done_seen || exp_idx != 16) begin
      errors++;
      $display("FAIL full_word_count: got words=%0d done=%0b expected 16 1", exp_idx, done_seen);
    end
    checks++;
    if (O_BUSY !== 1'b0 || O_DONE !== 1'b0 || O_VALID !== 1'b0) begin
      errors++;
      $display("FAIL full_back_idle: got busy=%0b done=%0b valid=%0b expected 0 0 0", O_BUSY, O_DONE, O_VALID);
    end
  endtask

  task automatic test_stall();
    int exp_idx;
    int cyc;
    int stall;
    bit done_seen;
    preset_rf();
    I_READY = 1'b1;
    start_dump();
    cyc = 1;
    exp_idx = 0;
    stall = 0;
    done_seen = 0;
    while (!done_seen && cyc < 80) begin
      if (O_VALID && O_INDEX == 4'd5 && stall < 3) begin
        I_READY = 1'b0;
        stall++;
        checks++;
        if (O_DATA !== 16'hA005 || O_INDEX !== 4'd5) begin
          errors++;
          $display("FAIL stall_hold: got data=%0h idx=%0d expected a005 5", O_DATA, O_INDEX);
        end
      end else begin
        I_READY = 1'b1;
      end
      if (O_VALID && I_READY) begin
        checks++;
        if (O_DATA !== 16'(16'hA000 + exp_idx) || O_INDEX !== 4'(exp_idx)) begin
          errors++;
          $display("FAIL stall_word: got data=%0h idx=%0d expected data=%0h idx=%0d",
                   O_DATA, O_INDEX, 16'(16'hA000 + exp_idx), exp_idx);
        end
        exp_idx++;
      end
      if (O_DONE) begin
        done_seen = 1;
        checks++;
        if (cyc != 36) begin
          errors++;
          $display("FAIL stall_done_cycle: got %0d expected 36", cyc);
        end
      end
      @(negedge I_CLK);
      cyc++;
    end
    I_READY = 1'b1;
    checks++;
    if (!done_seen || exp_idx != 16 || stall != 3) begin
      errors++;
      $display("FAIL stall_word_count: got words=%0d done=%0b stalls=%0d expected 16 1 3", exp_idx, done_seen, stall);
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit hit;
    preset_rf();
    I_READY = 1'b1;
    start_dump();
    cyc = 1;
    hit = 0;
    while (!hit && cyc < 40) begin
      if (O_VALID && O_INDEX == 4'd7) begin
        I_ABORT = 1'b1;
        hit = 1;
      end
      @(negedge I_CLK);
      cyc++;
    end
    I_ABORT = 1'b0;
    checks++;
    if (!hit || O_STATE !== 2'd0 || O_VALID !== 1'b0 || O_BUSY !== 1'b0 || O_DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort_to_idle: got hit=%0b st=%0d valid=%0b busy=%0b done=%0b expected 1 0 0 0 0",
               hit, O_STATE, O_VALID, O_BUSY, O_DONE);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge I_CLK);
      checks++;
      if (O_DONE !== 1'b0 || O_BUSY !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: got done=%0b busy=%0b expected 0 0", O_DONE, O_BUSY);
      end
    end
    start_dump();
    @(negedge I_CLK);
    checks++;
    if (O_VALID !== 1'b1 || O_INDEX !== 4'd0 || O_DATA !== 16'hA000) begin
      errors++;
      $display("FAIL abort_restart: got valid=%0b idx=%0d data=%0h expected 1 0 a000", O_VALID, O_INDEX, O_DATA);
    end
    I_READY = 1'b0;
    I_ABORT = 1'b1;
    @(negedge I_CLK);
    I_ABORT = 1'b0;
    I_READY = 1'b1;
    checks++;
    if (O_BUSY !== 1'b0 || O_VALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_send: got busy=%0b valid=%0b expected 0 0", O_BUSY, O_VALID);
    end
  endtask

  task automatic test_abort_idle();
    @(negedge I_CLK);
    I_START = 1'b1;
    I_ABORT = 1'b1;
    @(negedge I_CLK);
    I_START = 1'b0;
    I_ABORT = 1'b0;
    checks++;
    if (O_STATE !== 2'd1 || O_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle_ignored: got st=%0d busy=%0b expected 1 1", O_STATE, O_BUSY);
    end
    I_ABORT = 1'b1;
    @(negedge I_CLK);
    I_ABORT = 1'b0;
    checks++;
    if (O_STATE !== 2'd0 || O_VALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_fetch: got st=%0d valid=%0b expected 0 0", O_STATE, O_VALID);
    end
  endtask

  task automatic test_start_during_send();
    int exp_idx;
    int cyc;
    bit done_seen;
    preset_rf();
    I_READY = 1'b1;
    start_dump();
    cyc = 1;
    exp_idx = 0;
    done_seen = 0;
    while (!done_seen && cyc < 80) begin
      I_START = (O_VALID && O_INDEX == 4'd3);
      if (O_VALID) begin
        checks++;
        if (O_INDEX !== 4'(exp_idx) || O_DATA !== 16'(16'hA000 + exp_idx)) begin
          errors++;
          $display("FAIL start_ign_word: got idx=%0d data=%0h expected idx=%0d data=%0h",
                   O_INDEX, O_DATA, exp_idx, 16'(16'hA000 + exp_idx));
        end
        exp_idx++;
      end
      if (O_DONE) begin
        done_seen = 1;
        checks++;
        if (cyc != 33) begin
          errors++;
          $display("FAIL start_ign_done_cycle: got %0d expected 33", cyc);
        end
      end
      @(negedge I_CLK);
      cyc++;
    end
    I_START = 1'b0;
    checks++;
    if (!done_seen || exp_idx != 16 || O_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL start_ign_count: got words=%0d done=%0b busy=%0b expected 16 1 0", exp_idx, done_seen, O_BUSY);
    end
  endtask

  task automatic test_reset_mid_dump();
    int cyc;
    bit hit;
    preset_rf();
    I_READY = 1'b1;
    start_dump();
    cyc = 1;
    hit = 0;
    while (!hit && cyc < 40) begin
      if (O_VALID && O_INDEX == 4'd9) hit = 1;
      else begin
        @(negedge I_CLK);
        cyc++;
      end
    end
    I_NRESET = 1'b0;
    #1;
    checks++;
    if (!hit || {O_REG_ADDR, O_VALID, O_DATA, O_INDEX, O_LAST, O_BUSY, O_DONE, O_STATE} !== '0) begin
      errors++;
      $display("FAIL async_reset: got hit=%0b addr=%0h v=%0b d=%0h idx=%0h l=%0b b=%0b dn=%0b expected 1 and all 0",
               hit, O_REG_ADDR, O_VALID, O_DATA, O_INDEX, O_LAST, O_BUSY, O_DONE);
    end
    @(negedge I_CLK);
    I_NRESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge I_CLK);
      checks++;
      if (O_BUSY !== 1'b0 || O_VALID !== 1'b0) begin
        errors++;
        $display("FAIL reset_stays_idle: got busy=%0b valid=%0b expected 0 0", O_BUSY, O_VALID);
      end
    end
  endtask

  task automatic test_rf_write();
    logic [15:0] exp_q[$];
    int cyc;
    int words;
    bit done_seen;
    preset_rf();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'(16'hA000 + i));
    exp_q[2] = 16'h1234;
    I_READY = 1'b1;
    start_dump();
    cyc = 1;
    words = 0;
    done_seen = 0;
    while (!done_seen && cyc < 80) begin
      if (O_VALID && O_INDEX == 4'd1) rf[2] = 16'h1234;
      if (O_VALID) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rf_write_extra: got data=%0h expected no word", O_DATA);
        end else if (O_DATA !== exp_q[0] || O_INDEX !== 4'(words)) begin
          errors++;
          $display("FAIL rf_write_word: got data=%0h idx=%0d expected data=%0h idx=%0d",
                   O_DATA, O_INDEX, exp_q[0], words);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        words++;
      end
      if (O_DONE) done_seen = 1;
      @(negedge I_CLK);
      cyc++;
    end
    checks++;
    if (!done_seen || words != 16) begin
      errors++;
      $display("FAIL rf_write_count: got words=%0d done=%0b expected 16 1", words, done_seen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_dump();
    test_stall();
    test_abort();
    test_abort_idle();
    test_start_during_send();
    test_reset_mid_dump();
    test_rf_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
